// File: rtl/lfo_if.sv
// lfo_if: control/status bundle between the register file and one lfo_mod.
//   master : register-file side. It drives enable, mode, depth, speed and
//            retrigger (and onset_delay when LFO_ONSET_DELAY_EN is defined),
//            and it receives lfo_o and tick_o.
//   slave  : lfo_mod side, with the opposite directions.
// Signalling: these are level controls sampled on every clk edge. The only
// pulse is retrigger, which is meant to be high for exactly one cycle.
// There is no valid/ready handshake because every input is sampled each
// cycle. tick_o marks the cycle in which lfo_o holds a new value.
// Optional macro LFO_ONSET_DELAY_EN adds onset_delay [7:0].
interface lfo_if #(
  parameter int DEPTH_W = 4,
  parameter int SPEED_W = 8
);
  logic                    enable;
  logic [1:0]              mode;
  logic [DEPTH_W-1:0]      depth;
  logic [SPEED_W-1:0]      speed;
  logic                    retrigger;
`ifdef LFO_ONSET_DELAY_EN
  logic [7:0]              onset_delay;
`endif
  logic signed [DEPTH_W:0] lfo_o;
  logic                    tick_o;

`ifdef LFO_ONSET_DELAY_EN
  modport master (output enable, mode, depth, speed, retrigger, onset_delay,
                  input  lfo_o, tick_o);
  modport slave  (input  enable, mode, depth, speed, retrigger, onset_delay,
                  output lfo_o, tick_o);
`else
  modport master (output enable, mode, depth, speed, retrigger,
                  input  lfo_o, tick_o);
  modport slave  (input  enable, mode, depth, speed, retrigger,
                  output lfo_o, tick_o);
`endif
endinterface

// File: rtl/lfo_mod.sv
// lfo_mod: per-channel low-frequency oscillator. It produces a signed offset
// in the range -depth..+depth. The waveform is selected by mode:
// 0 triangle, 1 saw-up, 2 square, 3 sample-and-hold noise.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active low
//   bus  lfo_if.slave, carrying enable, mode, depth, speed, retrigger,
//        lfo_o (registered signed offset) and tick_o (new-value pulse)
// The phase advances once per prescaler tick, every speed+1 enabled cycles.
// Optional macro LFO_ONSET_DELAY_EN holds the output at 0 for onset_delay
// ticks after a retrigger or after a rising edge of enable.
module lfo_mod #(
  parameter int          DEPTH_W   = 4,
  parameter int          SPEED_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  lfo_if.slave bus
);
  localparam int VW = DEPTH_W + 1;
  typedef logic signed [VW-1:0] val_t;
  localparam val_t ONE = val_t'(1);

  logic [SPEED_W-1:0] div_d, div_q;
  val_t               val_d, val_q;
  logic               dir_d, dir_q;     // 0 = rising, 1 = falling
  logic [15:0]        lfsr_d, lfsr_q;
  val_t               lfo_d, lfo_q;
  logic               tick_d, tick_q;

  val_t        depth_s, ndepth_s, clamp_v, sample_v, step_v, wave_v;
  logic        dir_step, tick_due;
  logic [15:0] lfsr_adv;

`ifdef LFO_ONSET_DELAY_EN
  logic [7:0] onset_d, onset_q, onset_eff;
  logic       en_prev_d, en_prev_q;
`endif

  function automatic val_t clamp_fn(input val_t v, input val_t hi, input val_t lo);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  assign depth_s  = $signed({1'b0, bus.depth});
  assign ndepth_s = -depth_s;
  // A lowered depth takes effect on the held value before the mode step.
  assign clamp_v  = clamp_fn(val_q, depth_s, ndepth_s);
  // This is a Galois LFSR with taps 16,14,13,11, which is mask 0xB400 on a right shift.
  assign lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign sample_v = clamp_fn($signed(lfsr_adv[DEPTH_W:0]), depth_s, ndepth_s);

  // This block computes the next phase value for one tick. The square wave
  // reuses the triangle phase.
  always_comb begin
    step_v   = clamp_v;
    dir_step = dir_q;
    wave_v   = clamp_v;
    case (bus.mode)
      2'd0, 2'd2: begin
        if (depth_s != '0) begin
          if (!dir_q) begin
            if (clamp_v < depth_s) step_v = clamp_v + ONE;
            else begin
              dir_step = 1'b1;
              step_v   = clamp_v - ONE;
            end
          end else begin
            if (clamp_v > ndepth_s) step_v = clamp_v - ONE;
            else begin
              dir_step = 1'b0;
              step_v   = clamp_v + ONE;
            end
          end
        end
      end
      2'd1:    step_v = (clamp_v >= depth_s) ? ndepth_s : clamp_v + ONE;
      default: step_v = sample_v;
    endcase
    if (bus.mode == 2'd2) wave_v = dir_step ? ndepth_s : depth_s;
    else                  wave_v = step_v;
  end

  always_comb begin
    div_d    = div_q;
    val_d    = val_q;
    dir_d    = dir_q;
    lfsr_d   = lfsr_q;
    lfo_d    = lfo_q;
    tick_d   = 1'b0;
    tick_due = (div_q == bus.speed);
`ifdef LFO_ONSET_DELAY_EN
    // A rising edge of enable loads the delay and also allows that same cycle's tick to be consumed.
    en_prev_d = bus.enable;
    onset_eff = (bus.enable && !en_prev_q) ? bus.onset_delay : onset_q;
    onset_d   = onset_eff;
`endif
    if (!bus.enable) begin
      div_d = '0;
      val_d = '0;
      dir_d = 1'b0;
      lfo_d = '0;
`ifdef LFO_ONSET_DELAY_EN
      onset_d = '0;
`endif
    end else if (bus.retrigger) begin
      div_d  = '0;
      dir_d  = 1'b0;
      val_d  = (bus.mode == 2'd1) ? ndepth_s : '0;
      lfo_d  = val_d;
      tick_d = 1'b1;
`ifdef LFO_ONSET_DELAY_EN
      onset_d = bus.onset_delay;
      if (bus.onset_delay != 8'd0) begin
        lfo_d  = '0;
        tick_d = 1'b0;
      end
`endif
    end else if (tick_due) begin
      div_d = '0;
`ifdef LFO_ONSET_DELAY_EN
      // During onset the tick only counts down the delay, and the phase stays frozen.
      if (onset_eff != 8'd0) begin
        onset_d = onset_eff - 8'd1;
        lfo_d   = '0;
      end else
`endif
      begin
        val_d  = step_v;
        dir_d  = dir_step;
        lfo_d  = wave_v;
        tick_d = 1'b1;
        if (bus.mode == 2'd3) lfsr_d = lfsr_adv;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= '0;
      val_q  <= '0;
      dir_q  <= 1'b0;
      lfsr_q <= LFSR_SEED;
      lfo_q  <= '0;
      tick_q <= 1'b0;
`ifdef LFO_ONSET_DELAY_EN
      onset_q   <= '0;
      en_prev_q <= 1'b0;
`endif
    end else begin
      div_q  <= div_d;
      val_q  <= val_d;
      dir_q  <= dir_d;
      lfsr_q <= lfsr_d;
      lfo_q  <= lfo_d;
      tick_q <= tick_d;
`ifdef LFO_ONSET_DELAY_EN
      onset_q   <= onset_d;
      en_prev_q <= en_prev_d;
`endif
    end
  end

  assign bus.lfo_o  = lfo_q;
  assign bus.tick_o = tick_q;
endmodule

// File: tb/tb_lfo_mod.sv
// tb_lfo_mod: directed bench for lfo_mod. It uses DEPTH_W=4 and SPEED_W=8.
// Expected lfo_o values are queued in exp_q and then drained tick by tick.
module tb_lfo_mod;
  localparam int DEPTH_W = 4;
  localparam int SPEED_W = 8;
  typedef logic signed [DEPTH_W:0] lfo_t;

  logic clk;
  logic rst;
  lfo_if #(.DEPTH_W(DEPTH_W), .SPEED_W(SPEED_W)) bus ();

  lfo_mod #(.DEPTH_W(DEPTH_W), .SPEED_W(SPEED_W), .LFSR_SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  lfo_t exp_q[$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    exp_q.push_back(lfo_t'(v));
  endtask

  // Each queued value takes `period` cycles. tick_o stays low until the last
  // of those cycles, and lfo_o must then equal the queued value.
  task automatic drain(input string tag, input int period);
    lfo_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < period - 1; i++) begin
        step();
        check({tag, "_notick"}, 32'(bus.tick_o), 0);
      end
      step();
      check({tag, "_tick"}, 32'(bus.tick_o), 1);
      check({tag, "_lfo"}, $signed(bus.lfo_o), $signed(e));
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int clampi(input int v, input int d);
    if (v > d)  return d;
    if (v < -d) return -d;
    return v;
  endfunction

  int tri_seq[15] = '{1, 2, 3, 2, 1, 0, -1, -2, -3, -2, -1, 0, 1, 2, 3};
  int saw_seq[8]  = '{1, 2, -2, -1, 0, 1, 2, -2};
  int sq_seq[7]   = '{2, 2, -2, -2, -2, -2, 2};
  int clamp_seq[5] = '{0, -1, 0, 1, 0};

  initial begin
    logic [15:0] m;
    int          s;
    rst           = 1'b0;
    bus.enable    = 1'b0;
    bus.mode      = 2'd0;
    bus.depth     = '0;
    bus.speed     = '0;
    bus.retrigger = 1'b0;
`ifdef LFO_ONSET_DELAY_EN
    bus.onset_delay = 8'd0;
`endif

    // reset and idle
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_lfo", $signed(bus.lfo_o), 0);
      check("rst_tick", 32'(bus.tick_o), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_lfo", $signed(bus.lfo_o), 0);
      check("idle_tick", 32'(bus.tick_o), 0);
    end

    // triangle, depth 3, speed 1
    bus.depth  = 4'd3;
    bus.speed  = 8'd1;
    bus.mode   = 2'd0;
    bus.enable = 1'b1;
    foreach (tri_seq[i]) push(tri_seq[i]);
    drain("tri", 2);

    // retrigger coincident with a tick (div reaches speed on the second edge)
    step();
    check("pre_retrig_lfo", $signed(bus.lfo_o), 3);
    bus.retrigger = 1'b1;
    step();
    bus.retrigger = 1'b0;
    check("retrig_lfo", $signed(bus.lfo_o), 0);
    check("retrig_tick", 32'(bus.tick_o), 1);
    push(1); push(2); push(3);
    drain("after_retrig", 2);

    // depth lowered 3 -> 1 while val = 3
    bus.depth = 4'd1;
    foreach (clamp_seq[i]) push(clamp_seq[i]);
    drain("clamp", 2);

    // saw, depth 2, speed 0
    bus.enable = 1'b0;
    step();
    check("dis_lfo", $signed(bus.lfo_o), 0);
    bus.depth  = 4'd2;
    bus.speed  = 8'd0;
    bus.mode   = 2'd1;
    bus.enable = 1'b1;
    foreach (saw_seq[i]) push(saw_seq[i]);
    drain("saw", 1);

    // square, depth 2, speed 0
    bus.enable = 1'b0;
    step();
    check("dis2_tick", 32'(bus.tick_o), 0);
    bus.mode   = 2'd2;
    bus.enable = 1'b1;
    foreach (sq_seq[i]) push(sq_seq[i]);
    drain("square", 1);

    // noise from reset, depth 15, then depth 1
    rst = 1'b0;
    step();
    check("rst2_lfo", $signed(bus.lfo_o), 0);
    rst       = 1'b1;
    bus.mode  = 2'd3;
    bus.depth = 4'd15;
    m = 16'hACE1;
    for (int i = 0; i < 100; i++) begin
      m = lfsr_next(m);
      s = int'($signed(m[4:0]));
      push(clampi(s, 15));
    end
    drain("noise15", 1);
    bus.depth = 4'd1;
    for (int i = 0; i < 30; i++) begin
      m = lfsr_next(m);
      s = int'($signed(m[4:0]));
      push(clampi(s, 1));
    end
    drain("noise1", 1);

`ifdef LFO_ONSET_DELAY_EN
    rst = 1'b0;
    step();
    rst       = 1'b1;
    bus.mode  = 2'd0;
    bus.depth = 4'd3;
    push(1);
    drain("onset_pre", 1);
    bus.onset_delay = 8'd4;
    bus.retrigger   = 1'b1;
    step();
    bus.retrigger   = 1'b0;
    check("onset_retrig_lfo", $signed(bus.lfo_o), 0);
    check("onset_retrig_tick", 32'(bus.tick_o), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("onset_hold_lfo", $signed(bus.lfo_o), 0);
      check("onset_hold_tick", 32'(bus.tick_o), 0);
    end
    push(1); push(2);
    drain("onset_run", 1);
    rst = 1'b0;
    step();
    check("onset_rst_lfo", $signed(bus.lfo_o), 0);
    check("onset_rst_tick", 32'(bus.tick_o), 0);
    rst = 1'b1;
    bus.onset_delay = 8'd0;
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/lfo_mod.md
Name: lfo_mod

Overview:
- Multi-waveform low-frequency oscillator producing a signed pitch/volume offset per tone channel.
- Generalises the single-shape unipolar vibrato counter:
  - parametrised widths
  - bipolar output
  - four selectable waveforms
  - phase retrigger
  - update strobe
- Sits between the register file and the channel frequency/volume adder; one instance per channel.

Parameters:
- DEPTH_W, 4, width of depth input; lfo_o is DEPTH_W+1 bits two's complement.
- SPEED_W, 8, width of speed input and prescaler counter.
- LFSR_SEED, 16'hACE1, reset value of the noise LFSR; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- enable  in  1  run LFO; low forces idle.
- mode  in  2  waveform: 0 triangle, 1 saw-up, 2 square, 3 sample-and-hold noise.
- depth  in  DEPTH_W  peak amplitude, unsigned; output range -depth..+depth.
- speed  in  SPEED_W  prescaler terminal count; one tick every speed+1 cycles.
- retrigger  in  1  single-cycle pulse restarting the phase (note-on).
- lfo_o  out  DEPTH_W+1  signed modulation offset, registered.
- tick_o  out  1  one-cycle pulse in the cycle lfo_o takes a new value.

Behaviour:
- Reset (rst==0 at posedge): div=0, val=0, dir=up, lfsr=LFSR_SEED, lfo_o=0, tick_o=0.
- Disabled (enable==0, rst==1): div=0, val=0, dir=up, lfo_o=0, tick_o=0; lfsr holds its value.
- Prescaler: div increments each enabled cycle; when div==speed, div<=0 and a tick occurs. speed=0 ticks every cycle.
- Tick timing: on a tick edge val/dir/lfsr update, lfo_o<=new val and tick_o=1 for that cycle. No extra latency.
- Triangle (mode 0): internal val in -depth..+depth, step 1 per tick, no dwell at peaks.
  - Up: if val<depth then val+1; else dir<=down, val<=val-1.
  - Down: mirror of up.
  - depth==0: val stays 0, dir unchanged.
- Saw (mode 1): val+1 per tick; when val>=depth, next val=-depth (wrap). depth==0 holds 0.
- Square (mode 2): internal triangle phase advances exactly as mode 0; lfo_o=+depth while dir==up, -depth while dir==down. Period matches triangle.
- Noise (mode 3): lfsr (16-bit Galois, taps 16,14,13,11) advances once per tick. Sample s = lfsr[DEPTH_W:0] as signed, clamped to ±depth; val<=s.
- Depth decreased mid-run: at next tick val is first clamped to ±depth, then the mode step applies from the clamped value.
- Mode changed mid-run: val and dir are retained; new mode applies at the next tick.
- Retrigger has priority over a coincident tick:
  - div=0, dir=up, val=0 (saw: val=-depth).
  - lfo_o<=that val, tick_o=1.
  - lfsr not reset.
- Retrigger while enable==0 is ignored.
- rst low at any point overrides everything, including mid-period.

Optional Feature:
- Macro LFO_ONSET_DELAY_EN adds input onset_delay [7:0].
- With the macro: after retrigger or a rising edge of enable, lfo_o is held at 0 and tick_o stays low for onset_delay ticks. The prescaler runs but phase does not advance. Modulation then starts from the retrigger phase. onset_delay=0 behaves as without the macro.
- Without the macro: the port does not exist; modulation starts on the first tick.

Test Plan:
- Reset/idle: rst=0 two cycles, then enable=0 for 20 cycles -> lfo_o=0, tick_o=0 throughout.
- Triangle: depth=3, speed=1, mode=0 -> tick every 2 cycles; lfo_o sequence 1,2,3,2,1,0,-1,-2,-3,-2,-1,0,1…
- Saw and square: depth=2, speed=0.
  - mode 1 -> 1,2,-2,-1,0,1,2,-2…
  - mode 2 -> +2,+2,-2,-2,-2,-2,+2… (dir flips after reaching ±2).
- Noise: mode=3, depth=15, speed=0, from reset -> lfo_o equals the clamped low 5 bits of the reference-model LFSR over 100 ticks. Then set depth=1 -> all values within -1..1.
- Retrigger/clamp: triangle at lfo_o=3 with depth=3, then:
  - retrigger coincident with a tick -> lfo_o=0, next tick 1.
  - depth reduced 3->1 while val=3 -> next tick clamps to 1 then steps, giving 0.
- Onset delay (LFO_ONSET_DELAY_EN): onset_delay=4, speed=0, retrigger -> lfo_o=0 for 4 cycles, then 1,2,… ; mid-run rst=0 -> outputs zero next edge.
